// File: rtl/bus_autoseq.sv
// bus_autoseq: automatic address sequencer in front of the PlayBus controller.
//   Clock/reset : CK2HZ (rising edge), n_CLR (asynchronous, active low)
//   Inputs      : RUN (async run switch), ADD_SW[3:0], FUNC_SW[2:0], GO_SW, St[1:0] (controller state)
//   Outputs     : ADD[3:0], FUNC[2:0], GO to the controller; BUSY, DONE, FAULT status
//   Build option: AUTOSEQ_WRAP_EN makes a run wrap from LAST_ADD back to FIRST_ADD instead of ending in DONE.
module bus_autoseq #(
  parameter logic [3:0] FIRST_ADD = 4'd0,
  parameter logic [3:0] LAST_ADD = 4'd15,
  parameter int TIMEOUT = 7
) (
  input  logic       CK2HZ,
  input  logic       n_CLR,
  input  logic       RUN,
  input  logic [3:0] ADD_SW,
  input  logic [2:0] FUNC_SW,
  input  logic       GO_SW,
  input  logic [1:0] St,
  output logic [3:0] ADD,
  output logic [2:0] FUNC,
  output logic       GO,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAULT
);
  localparam int TW = $clog2(TIMEOUT + 1) > 3 ? $clog2(TIMEOUT + 1) : 3;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM = 3'd1;
  localparam logic [2:0] S_WAIT_END = 3'd2;
  localparam logic [2:0] S_WAIT_IDLE = 3'd3;
  localparam logic [2:0] S_STEP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ABORT = 3'd6;
  localparam logic [2:0] S_FAULT = 3'd7;
  logic [2:0] state, nxt;
  logic [3:0] addr_q, addr_d;
  logic [2:0] func_q, func_d;
  logic go_q, go_d;
  logic [TW-1:0] tmo;
  logic run_m, run_s, run_prev;
  logic idle, active, timed, tmo_hit, start;
  assign idle = state == S_IDLE;
  assign active = state inside {S_ARM, S_WAIT_END, S_WAIT_IDLE, S_STEP};
  assign timed = state inside {S_ARM, S_WAIT_END, S_WAIT_IDLE, S_ABORT};
  // tmo counts cycles already spent; firing one count early leaves the
  // state after exactly TIMEOUT cycles, as the counter reaches TIMEOUT.
  assign tmo_hit = timed && tmo == TW'(TIMEOUT - 1);
  assign start = run_s && !run_prev;
  assign ADD = idle ? ADD_SW : addr_q;
  assign FUNC = idle ? FUNC_SW : func_q;
  assign GO = idle ? GO_SW : go_q;
  assign BUSY = active;
  assign DONE = state == S_DONE;
  assign FAULT = state == S_FAULT;
  always_comb begin
    nxt = state;
    addr_d = addr_q;
    func_d = func_q;
    go_d = go_q;
    if (tmo_hit) begin
      nxt = S_FAULT;
      go_d = 1'b0;
    end else if (active && !run_s) begin
      nxt = S_ABORT;
      go_d = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start && St == 2'd0 && FUNC_SW != 3'd0) begin
          func_d = FUNC_SW;
          addr_d = FIRST_ADD;
          go_d = 1'b1;
          nxt = S_ARM;
        end
        S_ARM: begin
          go_d = 1'b1;
          nxt = St == 2'd1 ? S_WAIT_END : S_ARM;
        end
        S_WAIT_END: if (St == 2'd3) begin
          go_d = 1'b0;
          nxt = S_WAIT_IDLE;
        end
        S_WAIT_IDLE: nxt = St == 2'd0 ? S_STEP : S_WAIT_IDLE;
        S_STEP: if (addr_q == LAST_ADD) begin
`ifdef AUTOSEQ_WRAP_EN
          addr_d = FIRST_ADD;
          go_d = 1'b1;
          nxt = S_ARM;
`else
          go_d = 1'b0;
          nxt = S_DONE;
`endif
        end else begin
          addr_d = addr_q + 4'd1;
          go_d = 1'b1;
          nxt = S_ARM;
        end
        S_DONE: begin
          go_d = 1'b0;
          nxt = run_s ? S_DONE : S_IDLE;
        end
        S_ABORT: nxt = St == 2'd0 ? S_IDLE : S_ABORT;
        default: begin
          go_d = 1'b0;
          nxt = !run_s && St == 2'd0 ? S_IDLE : S_FAULT;
        end
      endcase
    end
  end
  always_ff @(posedge CK2HZ or negedge n_CLR)
    if (!n_CLR) begin
      state <= S_IDLE;
      addr_q <= FIRST_ADD;
      func_q <= 3'd0;
      go_q <= 1'b0;
      tmo <= '0;
      run_m <= 1'b0;
      run_s <= 1'b0;
      run_prev <= 1'b0;
    end else begin
      state <= nxt;
      addr_q <= addr_d;
      func_q <= func_d;
      go_q <= go_d;
      tmo <= (nxt != state || !timed) ? '0 : tmo + TW'(1);
      run_m <= RUN;
      run_s <= run_m;
      run_prev <= run_s;
    end
endmodule
